// File: rtl/ov5640_pwr_seq.sv
// ov5640_pwr_seq: OV5640 power-on and configuration sequencer.
// Walks the sensor through PWDN/RESETB power-on timing, then releases the I2C
// configuration engine and watches its done/error flags. Any error or timeout
// triggers a full power cycle, up to MAX_RETRY times, before the block gives up.
//
// Ports:
//   clk        system clock
//   reset_h    synchronous active-high reset
//   start      one-cycle request to begin or restart the sequence
//   cfg_done   configuration engine finished (level)
//   cfg_error  configuration engine error/NACK (level)
//   cam_pwdn   sensor PWDN pin, 1 = powered down
//   cam_rst_n  sensor RESETB pin, active-low
//   cfg_rst    active-high reset to the configuration engine
//   cam_ready  sensor powered and configured
//   seq_fail   all attempts exhausted
//   retry_cnt  retries consumed in the current sequence
//   seq_state  current FSM state, for debug
module ov5640_pwr_seq #(
    parameter int unsigned T_PWR_CYC         = 250000,
    parameter int unsigned T_RST_CYC         = 50000,
    parameter int unsigned T_BOOT_CYC        = 1000000,
    parameter int unsigned T_CFG_TIMEOUT_CYC = 50000000,
    parameter int unsigned MAX_RETRY         = 3
) (
    input  logic       clk,
    input  logic       reset_h,
    input  logic       start,
    input  logic       cfg_done,
    input  logic       cfg_error,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       cfg_rst,
    output logic       cam_ready,
    output logic       seq_fail,
    output logic [2:0] retry_cnt,
    output logic [2:0] seq_state
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned RETRY_W = 3;
    // Flags are ignored for this many cycles after the engine leaves reset.
    localparam int unsigned QUAL_CYC = 2;

    localparam logic [CNT_W-1:0]   PWR_LAST  = CNT_W'(T_PWR_CYC - 1);
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(T_RST_CYC - 1);
    localparam logic [CNT_W-1:0]   BOOT_LAST = CNT_W'(T_BOOT_CYC - 1);
    localparam logic [CNT_W-1:0]   CFG_LAST  = CNT_W'(T_CFG_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PWR   = 3'd1,
        S_RST   = 3'd2,
        S_BOOT  = 3'd3,
        S_CFG   = 3'd4,
        S_READY = 3'd5,
        S_FAIL  = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 pwdn_q, pwdn_d;
    logic                 rst_n_q, rst_n_d;
    logic                 cfg_rst_q, cfg_rst_d;
    logic                 ready_q, ready_d;
    logic                 fail_q, fail_d;

    logic                 flag_qual;
    logic                 err_ev;
    logic                 done_ev;
    logic                 timeout_ev;

    // CFG event decode: error beats done, and either flag beats the timeout.
    always_comb begin
        flag_qual  = (cnt_q >= CNT_W'(QUAL_CYC));
        err_ev     = flag_qual && cfg_error;
        done_ev    = flag_qual && cfg_done && !cfg_error;
        timeout_ev = (cnt_q == CFG_LAST);
    end

    // Next-state, dwell counter, retry count and decoded next outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_PWR;
                    retry_d = '0;
                end
            end
            S_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_BOOT;
                    cnt_d   = '0;
                end
            end
            S_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d = S_CFG;
                    cnt_d   = '0;
                end
            end
            S_CFG: begin
                if (err_ev || (timeout_ev && !done_ev)) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        state_d = S_PWR;
                        retry_d = retry_q + RETRY_W'(1);
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (done_ev) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY, S_FAIL: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_PWR;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase

        // Pin levels follow the state being entered so they register with it.
        pwdn_d    = 1'b1;
        rst_n_d   = 1'b0;
        cfg_rst_d = 1'b1;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        case (state_d)
            S_RST: begin
                pwdn_d = 1'b0;
            end
            S_BOOT: begin
                pwdn_d  = 1'b0;
                rst_n_d = 1'b1;
            end
            S_CFG: begin
                pwdn_d    = 1'b0;
                rst_n_d   = 1'b1;
                cfg_rst_d = 1'b0;
            end
            S_READY: begin
                pwdn_d    = 1'b0;
                rst_n_d   = 1'b1;
                cfg_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            S_FAIL: begin
                fail_d = 1'b1;
            end
            default: begin
                pwdn_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset_h) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            pwdn_q    <= 1'b1;
            rst_n_q   <= 1'b0;
            cfg_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pwdn_q    <= pwdn_d;
            rst_n_q   <= rst_n_d;
            cfg_rst_q <= cfg_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign cam_pwdn  = pwdn_q;
    assign cam_rst_n = rst_n_q;
    assign cfg_rst   = cfg_rst_q;
    assign cam_ready = ready_q;
    assign seq_fail  = fail_q;
    assign retry_cnt = retry_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_ov5640_pwr_seq.sv
// tb_ov5640_pwr_seq: directed bench for the OV5640 power/config sequencer
// using short dwell times so every state boundary can be stepped through.
module tb_ov5640_pwr_seq;

    localparam int unsigned T_PWR  = 4;
    localparam int unsigned T_RST  = 3;
    localparam int unsigned T_BOOT = 5;
    localparam int unsigned T_TO   = 20;
    localparam int unsigned N_RTY  = 2;

    logic       clk;
    logic       reset_h;
    logic       start;
    logic       cfg_done;
    logic       cfg_error;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       cfg_rst;
    logic       cam_ready;
    logic       seq_fail;
    logic [2:0] retry_cnt;
    logic [2:0] seq_state;

    int checks   = 0;
    int failures = 0;

    ov5640_pwr_seq #(
        .T_PWR_CYC        (T_PWR),
        .T_RST_CYC        (T_RST),
        .T_BOOT_CYC       (T_BOOT),
        .T_CFG_TIMEOUT_CYC(T_TO),
        .MAX_RETRY        (N_RTY)
    ) dut (
        .clk      (clk),
        .reset_h  (reset_h),
        .start    (start),
        .cfg_done (cfg_done),
        .cfg_error(cfg_error),
        .cam_pwdn (cam_pwdn),
        .cam_rst_n(cam_rst_n),
        .cfg_rst  (cfg_rst),
        .cam_ready(cam_ready),
        .seq_fail (seq_fail),
        .retry_cnt(retry_cnt),
        .seq_state(seq_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // All sequencer outputs against one expected set.
    task automatic check_all(input string tag, input int st, input int pwdn, input int rstn,
                             input int crst, input int rdy, input int fl, input int rty);
        check({tag, "_state"}, int'(seq_state), st);
        check({tag, "_pwdn"},  int'(cam_pwdn),  pwdn);
        check({tag, "_rstn"},  int'(cam_rst_n), rstn);
        check({tag, "_cfgrst"}, int'(cfg_rst),  crst);
        check({tag, "_ready"}, int'(cam_ready), rdy);
        check({tag, "_fail"},  int'(seq_fail),  fl);
        check({tag, "_retry"}, int'(retry_cnt), rty);
    endtask

    // Advance one clock; outputs are then examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in PWR cycle 0; steps to CFG cycle 0 checking every pin edge.
    task automatic walk_from_pwr(input string tag, input int rty, input bit poke_rst);
        check_all({tag, "_pwr0"}, 1, 1, 0, 1, 0, 0, rty);
        repeat (T_PWR - 1) tick();
        check_all({tag, "_pwrN"}, 1, 1, 0, 1, 0, 0, rty);
        tick();
        check_all({tag, "_rst0"}, 2, 0, 0, 1, 0, 0, rty);
        if (poke_rst) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (T_RST - 2) tick();
        end else begin
            repeat (T_RST - 1) tick();
        end
        check_all({tag, "_rstN"}, 2, 0, 0, 1, 0, 0, rty);
        tick();
        check_all({tag, "_boot0"}, 3, 0, 1, 1, 0, 0, rty);
        repeat (T_BOOT - 1) tick();
        check_all({tag, "_bootN"}, 3, 0, 1, 1, 0, 0, rty);
        tick();
        check_all({tag, "_cfg0"}, 4, 0, 1, 0, 0, 0, rty);
    endtask

    task automatic powerup(input string tag, input bit poke_rst);
        start = 1'b1;
        tick();
        start = 1'b0;
        walk_from_pwr(tag, 0, poke_rst);
    endtask

    initial begin
        reset_h   = 1'b1;
        start     = 1'b0;
        cfg_done  = 1'b0;
        cfg_error = 1'b0;
        repeat (3) tick();
        check_all("reset", 0, 1, 0, 1, 0, 0, 0);
        reset_h = 1'b0;
        repeat (5) tick();
        check_all("idle_hold", 0, 1, 0, 1, 0, 0, 0);

        // Nominal: done sampled in CFG cycle 6.
        powerup("nom", 1'b0);
        repeat (6) tick();
        cfg_done = 1'b1;
        check_all("nom_cfg6", 4, 0, 1, 0, 0, 0, 0);
        tick();
        check_all("nom_ready", 5, 0, 1, 0, 1, 0, 0);
        cfg_done = 1'b0;
        tick();
        cfg_error = 1'b1;
        tick();
        cfg_error = 1'b0;
        check_all("nom_ready_hold", 5, 0, 1, 0, 1, 0, 0);

        // Stale done in CFG cycles 0-1 is masked; real done sampled in cycle 8.
        powerup("stale", 1'b0);
        cfg_done = 1'b1;
        tick();
        check("stale_c1_state", int'(seq_state), 4);
        tick();
        check("stale_c2_state", int'(seq_state), 4);
        cfg_done = 1'b0;
        repeat (6) tick();
        cfg_done = 1'b1;
        check("stale_c8_state", int'(seq_state), 4);
        tick();
        cfg_done = 1'b0;
        check_all("stale_ready", 5, 0, 1, 0, 1, 0, 0);

        // Single error in CFG cycle 3, then success on the retry.
        powerup("err", 1'b0);
        repeat (3) tick();
        cfg_error = 1'b1;
        tick();
        cfg_error = 1'b0;
        walk_from_pwr("err_r1", 1, 1'b0);
        repeat (2) tick();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check_all("err_ready", 5, 0, 1, 0, 1, 0, 1);

        // Three timeouts exhaust the retries and land in FAIL.
        powerup("to", 1'b0);
        repeat (T_TO - 1) tick();
        check("to1_last_state", int'(seq_state), 4);
        tick();
        walk_from_pwr("to_r1", 1, 1'b0);
        repeat (T_TO - 1) tick();
        check("to2_last_state", int'(seq_state), 4);
        tick();
        walk_from_pwr("to_r2", 2, 1'b0);
        repeat (T_TO - 1) tick();
        check("to3_last_state", int'(seq_state), 4);
        tick();
        check_all("to_fail", 6, 1, 0, 1, 0, 1, 2);
        repeat (4) tick();
        check_all("to_fail_hold", 6, 1, 0, 1, 0, 1, 2);

        // Restart from FAIL, then simultaneous done+error takes the retry path.
        powerup("sim", 1'b0);
        repeat (2) tick();
        cfg_done  = 1'b1;
        cfg_error = 1'b1;
        tick();
        cfg_done  = 1'b0;
        cfg_error = 1'b0;
        check_all("sim_retry", 1, 1, 0, 1, 0, 0, 1);

        // Start during RST is ignored; timing through to CFG is unchanged.
        repeat (T_PWR - 1) tick();
        reset_h = 1'b1;
        tick();
        reset_h = 1'b0;
        check_all("pre_poke_reset", 0, 1, 0, 1, 0, 0, 0);
        powerup("poke", 1'b1);
        repeat (2) tick();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check_all("poke_ready", 5, 0, 1, 0, 1, 0, 0);

        // Reset during BOOT wins over a simultaneous start.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (T_PWR + T_RST) tick();
        check("rb_boot0_state", int'(seq_state), 3);
        tick();
        reset_h = 1'b1;
        start   = 1'b1;
        tick();
        reset_h = 1'b0;
        start   = 1'b0;
        check_all("rb_idle", 0, 1, 0, 1, 0, 0, 0);
        repeat (10) tick();
        check_all("rb_idle_hold", 0, 1, 0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
